// File: rtl/decode_pipe_stage.sv
// RV32 decode stage: register file with write-through bypass, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int CTRL_W   = 24,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [2:0]        ImmSrcD,
  input  logic              MemReadD,
  input  logic              WE3,
  input  logic [AW-1:0]     A3,
  input  logic [XLEN-1:0]   WD3,
  input  logic              FlushE,
  output logic              StallD,
  output logic              ValidE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [AW-1:0]     Rs1E,
  output logic [AW-1:0]     Rs2E,
  output logic [AW-1:0]     RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              MemReadE,
  output logic              IllegalRegE,
  output logic [XLEN-1:0]   a0
);

  logic [XLEN-1:0] rf [NREGS];
  logic [AW-1:0]   rs1, rs2, rd;
  logic            wr_ok;
  logic [XLEN-1:0] rd1, rd2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            illegal;
  logic            load;

  assign rs1 = InstrD[15 +: AW];
  assign rs2 = InstrD[20 +: AW];
  assign rd  = InstrD[7 +: AW];

  assign wr_ok = WE3 && !(ZERO_REG && A3 == '0);

  // NOTE: the register file is reset like any other flop because a mid-run
  // reset must leave every entry at zero; this rules out a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[A3] <= WD3;
    end
  end

  // Write-through: an instruction reading the register being written back
  // this cycle sees the new value.
  assign rd1 = (ZERO_REG && rs1 == '0) ? '0 : (wr_ok && A3 == rs1) ? WD3 : rf[rs1];
  assign rd2 = (ZERO_REG && rs2 == '0) ? '0 : (wr_ok && A3 == rs2) ? WD3 : rf[rs2];
  assign a0  = rf[AW'(10)];

  // Any index field beyond the implemented registers, regardless of format.
  assign illegal = (int'(InstrD[19:15]) >= NREGS) ||
                   (int'(InstrD[24:20]) >= NREGS) ||
                   (int'(InstrD[11:7])  >= NREGS);

  always_comb begin
    // NOTE: default first so every path assigns imm32 and no latch is inferred.
    imm32 = '0;
    case (ImmSrcD)
      3'b000: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      3'b001: imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      3'b010: imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                       InstrD[11:8], 1'b0};
      3'b011: imm32 = {InstrD[31:12], 12'b0};
      3'b100: imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                       InstrD[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  assign StallD = ValidD && ValidE && MemReadE && (RdE != '0) &&
                  ((RdE == rs1) || (RdE == rs2));

  // Flush, stall and an empty decode slot all produce the same all-zero bubble.
  assign load = ValidD && !FlushE && !StallD;

  // NOTE: non-blocking assignments so every E flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      CtrlE       <= '0;
      MemReadE    <= 1'b0;
      IllegalRegE <= 1'b0;
    end else begin
      ValidE      <= load;
      RD1E        <= load ? rd1 : '0;
      RD2E        <= load ? rd2 : '0;
      ImmExtE     <= load ? imm_ext : '0;
      PCE         <= load ? PCD : '0;
      Rs1E        <= load ? rs1 : '0;
      Rs2E        <= load ? rs2 : '0;
      RdE         <= load ? rd : '0;
      CtrlE       <= load ? CtrlD : '0;
      MemReadE    <= load && MemReadD;
      IllegalRegE <= load && illegal;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage configured as RV32E (16 registers).
module tb_decode_pipe_stage;

  localparam int XLEN = 32, NREGS = 16, CTRL_W = 24, AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       InstrD;
  logic              ValidD;
  logic [XLEN-1:0]   PCD;
  logic [CTRL_W-1:0] CtrlD;
  logic [2:0]        ImmSrcD;
  logic              MemReadD;
  logic              WE3;
  logic [AW-1:0]     A3;
  logic [XLEN-1:0]   WD3;
  logic              FlushE;
  logic              StallD, ValidE, MemReadE, IllegalRegE;
  logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, a0;
  logic [AW-1:0]     Rs1E, Rs2E, RdE;
  logic [CTRL_W-1:0] CtrlE;

  decode_pipe_stage #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .CtrlD(CtrlD),
    .ImmSrcD(ImmSrcD), .MemReadD(MemReadD), .WE3(WE3), .A3(A3), .WD3(WD3),
    .FlushE(FlushE), .StallD(StallD), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .CtrlE(CtrlE), .MemReadE(MemReadE), .IllegalRegE(IllegalRegE), .a0(a0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [31:0]       rd1, rd2, imm, pc;
    logic [3:0]        rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
    logic              memread, illegal;
  } e_t;

  e_t          sb[$];
  e_t          m_e;
  logic [31:0] m_rf [16];
  logic [31:0] pc_cnt = 32'h1000;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw_ins(input logic [4:0] rd, input logic [4:0] s1);
    return {12'h000, s1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {i[31:12], 12'b0};
      3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] rs);
    if (rs == 4'd0) return 32'h0;
    if (WE3 && A3 != 4'd0 && A3 == rs) return WD3;
    return m_rf[rs];
  endfunction

  task automatic clear_model();
    m_e = '{default: 0};
    for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
  endtask

  // One decode cycle: drive, check combinational outputs, push the expected
  // EX contents, then pop and compare after the edge.
  task automatic step(input logic [31:0] instr, input logic valid, input logic memread,
                      input logic [2:0] immsrc, input logic flush, input logic we,
                      input logic [3:0] a3, input logic [31:0] wd);
    e_t   e;
    logic exp_stall;
    logic [3:0] s1, s2;
    @(negedge clk);
    InstrD = instr; ValidD = valid; MemReadD = memread; ImmSrcD = immsrc;
    FlushE = flush; WE3 = we; A3 = a3; WD3 = wd;
    PCD = pc_cnt; pc_cnt += 4;
    CtrlD = CTRL_W'($urandom);
    #1;
    s1 = instr[18:15];
    s2 = instr[23:20];
    exp_stall = valid && m_e.valid && m_e.memread && (m_e.rd != 4'd0) &&
                ((m_e.rd == s1) || (m_e.rd == s2));
    check("StallD", StallD, exp_stall);
    check("a0", a0, m_rf[10]);
    if (flush || exp_stall || !valid) begin
      e = '{default: 0};
    end else begin
      e.valid   = 1'b1;
      e.rd1     = model_read(s1);
      e.rd2     = model_read(s2);
      e.imm     = model_imm(instr, immsrc);
      e.pc      = pc_cnt - 4;
      e.rs1     = s1;
      e.rs2     = s2;
      e.rd      = instr[10:7];
      e.ctrl    = CtrlD;
      e.memread = memread;
      e.illegal = instr[19] | instr[24] | instr[11];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("ValidE", ValidE, e.valid);
    check("RD1E", RD1E, e.rd1);
    check("RD2E", RD2E, e.rd2);
    check("ImmExtE", ImmExtE, e.imm);
    check("PCE", PCE, e.pc);
    check("Rs1E", Rs1E, e.rs1);
    check("Rs2E", Rs2E, e.rs2);
    check("RdE", RdE, e.rd);
    check("CtrlE", CtrlE, e.ctrl);
    check("MemReadE", MemReadE, e.memread);
    check("IllegalRegE", IllegalRegE, e.illegal);
    m_e = e;
    if (we && a3 != 4'd0) m_rf[a3] = wd;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    check("pre_rst_ValidE", ValidE, m_e.valid);
    rst = 1'b1;
    #1;
    check("rst_ValidE", ValidE, 1'b0);
    check("rst_RD1E", RD1E, 32'h0);
    check("rst_CtrlE", CtrlE, 32'h0);
    check("rst_a0", a0, 32'h0);
    check("rst_StallD", StallD, 1'b0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ri;
    rst = 1'b1;
    InstrD = '0; ValidD = 1'b0; PCD = '0; CtrlD = '0; ImmSrcD = '0;
    MemReadD = 1'b0; WE3 = 1'b0; A3 = '0; WD3 = '0; FlushE = 1'b0;
    clear_model();
    #12;
    check("reset_ValidE", ValidE, 1'b0);
    check("reset_RD1E", RD1E, 32'h0);
    check("reset_RD2E", RD2E, 32'h0);
    check("reset_ImmExtE", ImmExtE, 32'h0);
    check("reset_PCE", PCE, 32'h0);
    check("reset_RdE", RdE, 32'h0);
    check("reset_CtrlE", CtrlE, 32'h0);
    check("reset_MemReadE", MemReadE, 1'b0);
    check("reset_IllegalRegE", IllegalRegE, 1'b0);
    check("reset_StallD", StallD, 1'b0);
    check("reset_a0", a0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write-through bypass and x0 write suppression
    step(r_ins(3, 5, 0), 1, 0, 3'd0, 0, 1, 4'd5, 32'hDEADBEEF);
    check("bypass_RD1E", RD1E, 32'hDEADBEEF);
    step(r_ins(4, 0, 5), 1, 0, 3'd0, 0, 1, 4'd0, 32'h1234);
    check("x0_bypass_RD1E", RD1E, 32'h0);
    check("x5_RD2E", RD2E, 32'hDEADBEEF);
    step(r_ins(4, 0, 0), 1, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    check("x0_read_RD1E", RD1E, 32'h0);
    step(r_ins(6, 2, 3), 1, 0, 3'd1, 0, 1, 4'd10, 32'hA0A0_0010);
    step(32'h0, 0, 0, 3'd0, 0, 1, 4'd1, 32'h1111_1111);
    check("a0_value", a0, 32'hA0A0_0010);

    // Load-use stall, then the held instruction enters EX
    step(lw_ins(7, 1), 1, 1, 3'd0, 0, 0, 4'd0, 32'h0);
    check("lw_MemReadE", MemReadE, 1'b1);
    check("lw_RdE", RdE, 32'd7);
    step(r_ins(8, 7, 1), 1, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    check("stall_bubble_ValidE", ValidE, 1'b0);
    step(r_ins(8, 7, 1), 1, 0, 3'd0, 0, 1, 4'd7, 32'h7777_0007);
    check("after_stall_ValidE", ValidE, 1'b1);
    check("after_stall_RD2E", RD2E, 32'h1111_1111);

    // Flush alone, then flush during a stall
    step(r_ins(2, 1, 1), 1, 0, 3'd0, 1, 0, 4'd0, 32'h0);
    check("flush_CtrlE", CtrlE, 32'h0);
    step(lw_ins(7, 1), 1, 1, 3'd0, 0, 0, 4'd0, 32'h0);
    step(r_ins(8, 7, 1), 1, 0, 3'd0, 1, 0, 4'd0, 32'h0);
    step(r_ins(8, 7, 1), 1, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    check("post_flush_ValidE", ValidE, 1'b1);
    step(32'h0, 0, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    check("no_duplicate_ValidE", ValidE, 1'b0);

    // Immediate formats
    step(32'hFE000EE3, 1, 0, 3'd2, 0, 0, 4'd0, 32'h0);
    check("imm_B", ImmExtE, 32'hFFFFFFFC);
    step(32'h800000EF, 1, 0, 3'd4, 0, 0, 4'd0, 32'h0);
    check("imm_J", ImmExtE, 32'hFFF00000);
    step(32'hFFF0_0113, 1, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    step(32'h8000_0FA3, 1, 0, 3'd1, 0, 0, 4'd0, 32'h0);
    step(32'hABCD_E137, 1, 0, 3'd3, 0, 0, 4'd0, 32'h0);
    step(32'hFFFF_FFFF, 1, 0, 3'd5, 0, 0, 4'd0, 32'h0);

    // Out-of-range index on RV32E; the write to x1 still lands
    step(r_ins(17, 2, 3), 1, 0, 3'd0, 0, 1, 4'd1, 32'h0000_0055);
    check("illegal_rd", IllegalRegE, 1'b1);
    step(r_ins(0, 1, 0), 1, 0, 3'd0, 0, 0, 4'd0, 32'h0);
    check("x1_after_illegal", RD1E, 32'h0000_0055);

    mid_reset();

    for (int n = 0; n < 80; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 1) == 1) ri[19:15] = {1'b0, m_e.rd};
      step(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
           1'($urandom), 4'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
